// File: rtl/trap_sequencer_pkg.sv
// Shared encodings for the machine-mode trap sequencer: privilege levels,
// cause codes and the FSM state type.
package trap_sequencer_pkg;

  localparam logic [1:0] MMODE = 2'b11;
  localparam logic [1:0] UMODE = 2'b00;

  localparam logic [3:0] CAUSE_EXT_IRQ   = 4'd11;
  localparam logic [3:0] CAUSE_TIMER_IRQ = 4'd7;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRAP_SAVE = 2'd1,
    TRAP_JUMP = 2'd2,
    RET_JUMP  = 2'd3
  } state_e;

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline <-> trap sequencer signal bundle. The slave side is the sequencer,
// the master side is the execute stage / CSR file that drives it.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            i_instValid;
  logic [XLEN-1:0] i_pc;
  logic            i_exceptionFromInst;
  logic [3:0]      i_causeFromInst;
  logic            i_mret;
  logic            i_extIrq;
  logic            i_timerIrq;
  logic            i_meie;
  logic            i_mtie;
  logic [XLEN-1:0] i_mtvec;
  logic [XLEN-1:0] i_mepc;
  logic            i_csrMstatusWe;
  logic            i_csrMIE;
  logic            i_csrMPIE;
  logic [1:0]      i_csrMPP;

  logic            o_stall;
  logic            o_flush;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirectPC;
  logic            o_mepcWe;
  logic            o_mcauseWe;
  logic [XLEN-1:0] o_mepcWdata;
  logic [XLEN-1:0] o_mcauseWdata;
  logic [1:0]      o_privMode;
  logic            o_mstatusMIE;
  logic            o_mstatusMPIE;
  logic [1:0]      o_mstatusMPP;

  modport slave (
    input  i_instValid, i_pc, i_exceptionFromInst, i_causeFromInst, i_mret,
           i_extIrq, i_timerIrq, i_meie, i_mtie, i_mtvec, i_mepc,
           i_csrMstatusWe, i_csrMIE, i_csrMPIE, i_csrMPP,
    output o_stall, o_flush, o_redirect, o_redirectPC, o_mepcWe, o_mcauseWe,
           o_mepcWdata, o_mcauseWdata, o_privMode, o_mstatusMIE,
           o_mstatusMPIE, o_mstatusMPP
  );

  modport master (
    output i_instValid, i_pc, i_exceptionFromInst, i_causeFromInst, i_mret,
           i_extIrq, i_timerIrq, i_meie, i_mtie, i_mtvec, i_mepc,
           i_csrMstatusWe, i_csrMIE, i_csrMPIE, i_csrMPP,
    input  o_stall, o_flush, o_redirect, o_redirectPC, o_mepcWe, o_mcauseWe,
           o_mepcWdata, o_mcauseWdata, o_privMode, o_mstatusMIE,
           o_mstatusMPIE, o_mstatusMPP
  );
endinterface

// File: rtl/trap_vector_calc.sv
// Trap target PC from mtvec: direct mode, or vectored (base + 4*code) for
// interrupts only. Reserved modes 2 and 3 behave as direct.
module trap_vector_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_mtvec,
  input  logic            i_isIrq,
  input  logic [3:0]      i_code,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  always_comb begin
    base   = i_mtvec & ~XLEN'(3);
    offset = XLEN'(i_code) << 2;
    if (i_isIrq && (i_mtvec[1:0] == 2'b01)) begin
      o_target = base + offset;
    end else begin
      o_target = base;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: arbitrates exceptions and
// interrupts, emits mepc/mcause writes, redirects fetch and updates mstatus.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  trap_sequencer_if.slave  bus
);

  // state     | meaning
  // IDLE      | watching execute stage for exceptions, irqs and mret
  // TRAP_SAVE | writing mepc/mcause, pipeline stalled and flushed
  // TRAP_JUMP | redirecting to trap vector, entering M-mode
  // RET_JUMP  | redirecting to mepc, restoring privilege from MPP

  state_e          state_q;
  logic            irq_q;
  logic [3:0]      code_q;
  logic [1:0]      priv_q;
  logic            mie_q;
  logic            mpie_q;
  logic [1:0]      mpp_q;

  logic            stall_q;
  logic            flush_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            mepc_we_q;
  logic            mcause_we_q;
  logic [XLEN-1:0] mepc_wdata_q;
  logic [XLEN-1:0] mcause_wdata_q;

  logic            irq_ok;
  logic            take_trap_d;
  logic            take_mret_d;
  logic            trap_irq_d;
  logic [3:0]      trap_code_d;
  logic [XLEN-1:0] vec_pc;

  always_comb begin
    irq_ok      = mie_q | (priv_q != MMODE);
    take_trap_d = 1'b0;
    take_mret_d = 1'b0;
    trap_irq_d  = 1'b0;
    trap_code_d = 4'd0;
    if (bus.i_instValid) begin
      if (bus.i_exceptionFromInst) begin
        take_trap_d = 1'b1;
        trap_code_d = bus.i_causeFromInst;
      end else if (bus.i_mret && (priv_q != MMODE)) begin
        take_trap_d = 1'b1;
        trap_code_d = CAUSE_ILLEGAL;
      end else if (bus.i_extIrq && bus.i_meie && irq_ok) begin
        take_trap_d = 1'b1;
        trap_irq_d  = 1'b1;
        trap_code_d = CAUSE_EXT_IRQ;
      end else if (bus.i_timerIrq && bus.i_mtie && irq_ok) begin
        take_trap_d = 1'b1;
        trap_irq_d  = 1'b1;
        trap_code_d = CAUSE_TIMER_IRQ;
      end else if (bus.i_mret) begin
        take_mret_d = 1'b1;
      end
    end
  end

  trap_vector_calc #(.XLEN(XLEN)) u_vec (
    .i_mtvec  (bus.i_mtvec),
    .i_isIrq  (irq_q),
    .i_code   (code_q),
    .o_target (vec_pc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      irq_q          <= 1'b0;
      code_q         <= 4'd0;
      priv_q         <= RESET_PRIV;
      mie_q          <= 1'b0;
      mpie_q         <= 1'b0;
      mpp_q          <= UMODE;
      stall_q        <= 1'b0;
      flush_q        <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      mepc_we_q      <= 1'b0;
      mcause_we_q    <= 1'b0;
      mepc_wdata_q   <= '0;
      mcause_wdata_q <= '0;
    end else begin
      // Every pulse and its data default low; only the active state raises them.
      stall_q        <= 1'b0;
      flush_q        <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      mepc_we_q      <= 1'b0;
      mcause_we_q    <= 1'b0;
      mepc_wdata_q   <= '0;
      mcause_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (take_trap_d) begin
            state_q        <= TRAP_SAVE;
            irq_q          <= trap_irq_d;
            code_q         <= trap_code_d;
            mepc_we_q      <= 1'b1;
            mepc_wdata_q   <= bus.i_pc & ~XLEN'(3);
            mcause_we_q    <= 1'b1;
            mcause_wdata_q <= {trap_irq_d, {(XLEN-5){1'b0}}, trap_code_d};
            stall_q        <= 1'b1;
            flush_q        <= 1'b1;
          end else if (take_mret_d) begin
            state_q       <= RET_JUMP;
            redirect_q    <= 1'b1;
            redirect_pc_q <= bus.i_mepc & ~XLEN'(3);
            flush_q       <= 1'b1;
          end else if (bus.i_csrMstatusWe) begin
            mie_q  <= bus.i_csrMIE;
            mpie_q <= bus.i_csrMPIE;
            mpp_q  <= bus.i_csrMPP;
          end
        end
        TRAP_SAVE: begin
          state_q       <= TRAP_JUMP;
          redirect_q    <= 1'b1;
          redirect_pc_q <= vec_pc;
          flush_q       <= 1'b1;
        end
        TRAP_JUMP: begin
          state_q <= IDLE;
          mpie_q  <= mie_q;
          mie_q   <= 1'b0;
          mpp_q   <= priv_q;
          priv_q  <= MMODE;
        end
        RET_JUMP: begin
          state_q <= IDLE;
          mie_q   <= mpie_q;
          mpie_q  <= 1'b1;
          priv_q  <= mpp_q;
          mpp_q   <= UMODE;
        end
      endcase
    end
  end

  assign bus.o_stall       = stall_q;
  assign bus.o_flush       = flush_q;
  assign bus.o_redirect    = redirect_q;
  assign bus.o_redirectPC  = redirect_pc_q;
  assign bus.o_mepcWe      = mepc_we_q;
  assign bus.o_mcauseWe    = mcause_we_q;
  assign bus.o_mepcWdata   = mepc_wdata_q;
  assign bus.o_mcauseWdata = mcause_wdata_q;
  assign bus.o_privMode    = priv_q;
  assign bus.o_mstatusMIE  = mie_q;
  assign bus.o_mstatusMPIE = mpie_q;
  assign bus.o_mstatusMPP  = mpp_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected mepc/mcause writes and redirect
// targets are queued when stimulus is driven and checked when the DUT emits them.
module tb_trap_sequencer;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;

  trap_sequencer_if #(.XLEN(XLEN)) bus ();

  trap_sequencer #(.XLEN(XLEN), .RESET_PRIV(2'b11)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mepc;
    logic [31:0] mcause;
  } save_t;

  save_t       q_save[$];
  logic [31:0] q_redir[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.i_instValid         = 1'b0;
    bus.i_exceptionFromInst = 1'b0;
    bus.i_causeFromInst     = 4'd0;
    bus.i_mret              = 1'b0;
    bus.i_extIrq            = 1'b0;
    bus.i_timerIrq          = 1'b0;
    bus.i_meie              = 1'b0;
    bus.i_mtie              = 1'b0;
    bus.i_csrMstatusWe      = 1'b0;
    bus.i_csrMIE            = 1'b0;
    bus.i_csrMPIE           = 1'b0;
    bus.i_csrMPP            = 2'b00;
  endtask

  task automatic sw_mstatus(input logic mie, input logic mpie, input logic [1:0] mpp);
    bus.i_csrMstatusWe = 1'b1;
    bus.i_csrMIE       = mie;
    bus.i_csrMPIE      = mpie;
    bus.i_csrMPP       = mpp;
    step();
    clear_events();
  endtask

  task automatic chk_status(input string tag, input logic [1:0] priv, input logic mie,
                            input logic mpie, input logic [1:0] mpp);
    chk({tag, "_priv"}, 64'(bus.o_privMode), 64'(priv));
    chk({tag, "_mie"},  64'(bus.o_mstatusMIE), 64'(mie));
    chk({tag, "_mpie"}, 64'(bus.o_mstatusMPIE), 64'(mpie));
    chk({tag, "_mpp"},  64'(bus.o_mstatusMPP), 64'(mpp));
  endtask

  // Output-side scoreboard: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_mepcWe) begin
        if (q_save.size() == 0) begin
          chk("unexpected_save", 64'(bus.o_mepcWe), 64'd0);
        end else begin
          save_t e;
          e = q_save.pop_front();
          chk("mepc_wdata", 64'(bus.o_mepcWdata), 64'(e.mepc));
          chk("mcause_wdata", 64'(bus.o_mcauseWdata), 64'(e.mcause));
          chk("mcause_we", 64'(bus.o_mcauseWe), 64'd1);
          chk("save_stall", 64'(bus.o_stall), 64'd1);
        end
      end
      if (bus.o_redirect) begin
        if (q_redir.size() == 0) begin
          chk("unexpected_redirect", 64'(bus.o_redirect), 64'd0);
        end else begin
          logic [31:0] r;
          r = q_redir.pop_front();
          chk("redirect_pc", 64'(bus.o_redirectPC), 64'(r));
          chk("redirect_flush", 64'(bus.o_flush), 64'd1);
        end
      end
    end
  end

  initial begin
    logic any_pulse;
    rst_n       = 1'b0;
    bus.i_pc    = '0;
    bus.i_mtvec = '0;
    bus.i_mepc  = '0;
    clear_events();
    repeat (3) step();

    // Reset values
    chk_status("rst", 2'b11, 1'b0, 1'b0, 2'b00);
    chk("rst_pulses", 64'({bus.o_stall, bus.o_flush, bus.o_redirect, bus.o_mepcWe, bus.o_mcauseWe}), 64'd0);
    chk("rst_data", 64'(bus.o_redirectPC | bus.o_mepcWdata | bus.o_mcauseWdata), 64'd0);
    rst_n = 1'b1;
    step();

    // mret in M-mode: MPIE=1, MPP=00, mepc 0x344 -> redirect next cycle
    sw_mstatus(1'b0, 1'b1, 2'b00);
    chk_status("swwr", 2'b11, 1'b0, 1'b1, 2'b00);
    bus.i_mepc = 32'h344;
    q_redir.push_back(32'h344);
    bus.i_instValid = 1'b1;
    bus.i_mret      = 1'b1;
    step();
    chk("mret_redirect_lat", 64'(bus.o_redirect), 64'd1);
    clear_events();
    step();
    chk("mret_redirect_pulse", 64'(bus.o_redirect), 64'd0);
    chk_status("mret", 2'b00, 1'b1, 1'b1, 2'b00);

    // U-mode ecall at 0x100, mtvec 0x200
    bus.i_pc    = 32'h100;
    bus.i_mtvec = 32'h200;
    q_save.push_back('{mepc: 32'h100, mcause: 32'd8});
    q_redir.push_back(32'h200);
    bus.i_instValid         = 1'b1;
    bus.i_exceptionFromInst = 1'b1;
    bus.i_causeFromInst     = 4'd8;
    step();
    chk("ecall_save_lat", 64'(bus.o_mepcWe), 64'd1);
    chk("ecall_no_early_redir", 64'(bus.o_redirect), 64'd0);
    clear_events();
    step();
    chk("ecall_redirect_lat", 64'(bus.o_redirect), 64'd1);
    chk("ecall_save_pulse", 64'(bus.o_mepcWe), 64'd0);
    step();
    chk("ecall_redirect_pulse", 64'(bus.o_redirect), 64'd0);
    chk_status("ecall", 2'b11, 1'b0, 1'b1, 2'b00);

    // Drop back to U-mode, then a U-mode mret must trap as illegal (cause 2)
    q_redir.push_back(32'h344);
    bus.i_instValid = 1'b1;
    bus.i_mret      = 1'b1;
    step();
    clear_events();
    step();
    chk("to_umode_priv", 64'(bus.o_privMode), 64'd0);
    bus.i_pc = 32'h104;
    q_save.push_back('{mepc: 32'h104, mcause: 32'd2});
    q_redir.push_back(32'h200);
    bus.i_instValid = 1'b1;
    bus.i_mret      = 1'b1;
    step();
    chk("illmret_save", 64'(bus.o_mepcWe), 64'd1);
    clear_events();
    repeat (2) step();
    chk_status("illmret", 2'b11, 1'b0, 1'b1, 2'b00);

    // External irq, vectored mtvec 0x201 -> 0x200 + 4*11
    sw_mstatus(1'b1, 1'b0, 2'b11);
    bus.i_pc    = 32'h403;
    bus.i_mtvec = 32'h201;
    q_save.push_back('{mepc: 32'h400, mcause: 32'h8000000B});
    q_redir.push_back(32'h22C);
    bus.i_instValid = 1'b1;
    bus.i_extIrq    = 1'b1;
    bus.i_meie      = 1'b1;
    step();
    chk("ext_save", 64'(bus.o_mepcWe), 64'd1);
    clear_events();
    repeat (2) step();
    chk_status("ext", 2'b11, 1'b0, 1'b1, 2'b11);

    // Exception beats a simultaneous timer irq; events held during the sequence are ignored
    sw_mstatus(1'b1, 1'b1, 2'b11);
    bus.i_pc = 32'h500;
    q_save.push_back('{mepc: 32'h500, mcause: 32'd5});
    q_redir.push_back(32'h200);
    bus.i_instValid         = 1'b1;
    bus.i_exceptionFromInst = 1'b1;
    bus.i_causeFromInst     = 4'd5;
    bus.i_timerIrq          = 1'b1;
    bus.i_mtie              = 1'b1;
    step();
    chk("exc_tmr_save", 64'(bus.o_mepcWe), 64'd1);
    step();
    bus.i_exceptionFromInst = 1'b0;
    chk("exc_tmr_redir", 64'(bus.o_redirect), 64'd1);
    step();
    chk("tmr_masked_in_m", 64'(bus.o_stall), 64'd0);
    bus.i_instValid = 1'b0;
    sw_mstatus(1'b1, 1'b1, 2'b11);
    bus.i_timerIrq = 1'b1;
    bus.i_mtie     = 1'b1;
    chk("tmr_enable_write", 64'(bus.o_mstatusMIE), 64'd1);

    // Pending timer now taken; same-cycle software mstatus write is dropped
    bus.i_pc = 32'h600;
    q_save.push_back('{mepc: 32'h600, mcause: 32'h80000007});
    q_redir.push_back(32'h21C);
    bus.i_instValid    = 1'b1;
    bus.i_csrMstatusWe = 1'b1;
    bus.i_csrMIE       = 1'b0;
    bus.i_csrMPIE      = 1'b0;
    bus.i_csrMPP       = 2'b00;
    step();
    chk("tmr_save", 64'(bus.o_mepcWe), 64'd1);
    clear_events();
    repeat (2) step();
    chk_status("tmr", 2'b11, 1'b0, 1'b1, 2'b11);

    // Reset during TRAP_SAVE: no redirect, reset state restored
    bus.i_pc    = 32'h700;
    bus.i_mtvec = 32'h200;
    bus.i_instValid         = 1'b1;
    bus.i_exceptionFromInst = 1'b1;
    bus.i_causeFromInst     = 4'd3;
    step();
    chk("rstmid_in_save", 64'(bus.o_mepcWe), 64'd1);
    rst_n = 1'b0;
    clear_events();
    #1;
    chk("rstmid_pulses", 64'({bus.o_stall, bus.o_flush, bus.o_redirect, bus.o_mepcWe, bus.o_mcauseWe}), 64'd0);
    chk("rstmid_data", 64'(bus.o_redirectPC | bus.o_mepcWdata | bus.o_mcauseWdata), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    any_pulse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_pulse = any_pulse | bus.o_redirect | bus.o_mepcWe | bus.o_stall;
    end
    chk("rstmid_no_redirect", 64'(any_pulse), 64'd0);
    chk_status("rstmid", 2'b11, 1'b0, 1'b0, 2'b00);

    // Sequencer accepts immediately afterwards, so it is back in IDLE
    bus.i_pc = 32'h800;
    q_save.push_back('{mepc: 32'h800, mcause: 32'd8});
    q_redir.push_back(32'h200);
    bus.i_instValid         = 1'b1;
    bus.i_exceptionFromInst = 1'b1;
    bus.i_causeFromInst     = 4'd8;
    step();
    chk("post_rst_save", 64'(bus.o_mepcWe), 64'd1);
    clear_events();
    repeat (3) step();

    chk("save_queue_drained", 64'(q_save.size()), 64'd0);
    chk("redir_queue_drained", 64'(q_redir.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
